// File: rtl/qam_pkg.sv
// Shared 16-QAM definitions: Gray-coded axis levels (common with the transmit mapper)
// and the accumulator sizing helper.
package qam_pkg;

  localparam logic [1:0] QAM_LVL_M3 = 2'b00;
  localparam logic [1:0] QAM_LVL_M1 = 2'b01;
  localparam logic [1:0] QAM_LVL_P1 = 2'b11;
  localparam logic [1:0] QAM_LVL_P3 = 2'b10;

  // Full-precision product width plus growth for summing sym_len products
  function automatic int acc_width(input int data_width, input int sym_len);
    return 2 * data_width + $clog2(sym_len);
  endfunction

endpackage

// File: rtl/qam_slicer.sv
// One-axis 16-QAM decision: compares a signed symbol sum against +/- an unsigned
// inner/outer threshold and returns the Gray-coded level.
module qam_slicer
  import qam_pkg::*;
#(
  parameter int ACC_WIDTH = 34
) (
  input  logic [ACC_WIDTH-1:0] sum,
  input  logic [ACC_WIDTH-2:0] thresh,
  output logic [1:0]           lvl
);

  logic signed [ACC_WIDTH-1:0] sum_s;
  logic signed [ACC_WIDTH-1:0] t_pos_s;
  logic signed [ACC_WIDTH-1:0] t_neg_s;

  assign sum_s   = $signed(sum);
  assign t_pos_s = $signed({1'b0, thresh});
  // Zero-extended threshold is at most 2^(W-1)-1, so its negation always fits
  assign t_neg_s = -t_pos_s;

  // Decision regions, outermost first; T=0 collapses to a pure sign decision
  always_comb begin
    lvl = QAM_LVL_M3;
    if (sum_s >= t_pos_s) begin
      lvl = QAM_LVL_P3;
    end else if (sum_s[ACC_WIDTH-1] == 1'b0) begin
      lvl = QAM_LVL_P1;
    end else if (sum_s >= t_neg_s) begin
      lvl = QAM_LVL_M1;
    end else begin
      lvl = QAM_LVL_M3;
    end
  end

endmodule

// File: rtl/qam_iq_demod.sv
// Coherent I/Q correlator with integrate-and-dump and 16-QAM slicing.
// Optional QAM_IQ_DEMOD_SOFT_OUT_EN exposes the registered symbol sums as soft_i/soft_q.
module qam_iq_demod
  import qam_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SYM_LEN    = 64,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, SYM_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] rx_sample,
  input  logic [DATA_WIDTH-1:0] lo_cos,
  input  logic [DATA_WIDTH-1:0] lo_sin,
  input  logic                  sym_start,
  input  logic [ACC_WIDTH-2:0]  thresh,
  output logic                  sym_valid,
  output logic [1:0]            sym_i,
  output logic [1:0]            sym_q
`ifdef QAM_IQ_DEMOD_SOFT_OUT_EN
  ,
  output logic [ACC_WIDTH-1:0]  soft_i,
  output logic [ACC_WIDTH-1:0]  soft_q
`endif
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(SYM_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic signed [PW-1:0]        prod_i_s;
  logic signed [PW-1:0]        prod_q_s;
  logic signed [ACC_WIDTH-1:0] p_i_r;
  logic signed [ACC_WIDTH-1:0] p_q_r;
  logic                        v1_r;
  logic                        st1_r;
  logic signed [ACC_WIDTH-1:0] acc_i_r;
  logic signed [ACC_WIDTH-1:0] acc_q_r;
  logic [CNT_W-1:0]            cnt_r;
  logic signed [ACC_WIDTH-1:0] sum_i_s;
  logic signed [ACC_WIDTH-1:0] sum_q_s;
  logic                        dump_s;
  logic [1:0]                  lvl_i_s;
  logic [1:0]                  lvl_q_s;

  // Q uses -(rx*sin) because the transmitter forms I*cos - Q*sin
  assign prod_i_s = PW'($signed(rx_sample)) * PW'($signed(lo_cos));
  assign prod_q_s = -(PW'($signed(rx_sample)) * PW'($signed(lo_sin)));

  // Stage 1: register sign-extended products with their valid/start qualifiers
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r  <= 1'b0;
      st1_r <= 1'b0;
      p_i_r <= '0;
      p_q_r <= '0;
    end else if (in_valid) begin
      v1_r  <= 1'b1;
      st1_r <= sym_start;
      p_i_r <= ACC_WIDTH'(prod_i_s);
      p_q_r <= ACC_WIDTH'(prod_q_s);
    end else begin
      v1_r  <= 1'b0;
      st1_r <= 1'b0;
    end
  end

  assign sum_i_s = acc_i_r + p_i_r;
  assign sum_q_s = acc_q_r + p_q_r;
  // A start on the last count restarts the symbol instead of dumping it
  assign dump_s  = v1_r && !st1_r && (cnt_r == CNT_LAST);

  qam_slicer #(.ACC_WIDTH(ACC_WIDTH)) u_slicer_i (
    .sum    (sum_i_s),
    .thresh (thresh),
    .lvl    (lvl_i_s)
  );

  qam_slicer #(.ACC_WIDTH(ACC_WIDTH)) u_slicer_q (
    .sum    (sum_q_s),
    .thresh (thresh),
    .lvl    (lvl_q_s)
  );

  // Stage 2: integrate-and-dump with registered decision outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_i_r   <= '0;
      acc_q_r   <= '0;
      cnt_r     <= '0;
      sym_valid <= 1'b0;
      sym_i     <= 2'b00;
      sym_q     <= 2'b00;
    end else begin
      sym_valid <= 1'b0;
      if (v1_r) begin
        if (st1_r) begin
          acc_i_r <= p_i_r;
          acc_q_r <= p_q_r;
          cnt_r   <= CNT_ONE;
        end else if (dump_s) begin
          acc_i_r   <= '0;
          acc_q_r   <= '0;
          cnt_r     <= '0;
          sym_valid <= 1'b1;
          sym_i     <= lvl_i_s;
          sym_q     <= lvl_q_s;
        end else begin
          acc_i_r <= sum_i_s;
          acc_q_r <= sum_q_s;
          cnt_r   <= cnt_r + CNT_ONE;
        end
      end
    end
  end

`ifdef QAM_IQ_DEMOD_SOFT_OUT_EN
  // Soft sums captured alongside the hard decision for EVM / soft decoding
  always_ff @(posedge clk) begin
    if (rst) begin
      soft_i <= '0;
      soft_q <= '0;
    end else if (dump_s) begin
      soft_i <= sum_i_s;
      soft_q <= sum_q_s;
    end else begin
      soft_i <= soft_i;
      soft_q <= soft_q;
    end
  end
`else
  // Without soft outputs the final sums exist only combinationally at the slicers
`endif

endmodule

// File: tb/tb_qam_iq_demod.sv
// Self-checking bench for qam_iq_demod: directed scenarios plus randomized symbols
// checked cycle-by-cycle against a queue-based reference model.
module tb_qam_iq_demod;

  localparam int DW = 16;
  localparam int SL = 4;
  localparam int AW = 2 * DW + $clog2(SL);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] rx_sample;
  logic [DW-1:0] lo_cos;
  logic [DW-1:0] lo_sin;
  logic          sym_start;
  logic [AW-2:0] thresh;
  logic          sym_valid;
  logic [1:0]    sym_i;
  logic [1:0]    sym_q;
`ifdef QAM_IQ_DEMOD_SOFT_OUT_EN
  logic [AW-1:0] soft_i;
  logic [AW-1:0] soft_q;
`endif

  always #5 clk = ~clk;

  qam_iq_demod #(.DATA_WIDTH(DW), .SYM_LEN(SL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .rx_sample (rx_sample),
    .lo_cos    (lo_cos),
    .lo_sin    (lo_sin),
    .sym_start (sym_start),
    .thresh    (thresh),
    .sym_valid (sym_valid),
    .sym_i     (sym_i),
    .sym_q     (sym_q)
`ifdef QAM_IQ_DEMOD_SOFT_OUT_EN
    ,
    .soft_i    (soft_i),
    .soft_q    (soft_q)
`endif
  );

  typedef struct {
    int         at;
    logic [1:0] li;
    logic [1:0] lq;
    longint     si;
    longint     sq;
  } exp_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  longint     qi[$];
  longint     qq[$];
  exp_t       sched[$];
  logic [1:0] last_i  = 2'b00;
  logic [1:0] last_q  = 2'b00;
  longint     last_si = 0;
  longint     last_sq = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // 16-QAM decision straight from the region definitions
  function automatic logic [1:0] slice(input longint s, input longint t);
    if (s >= t)       return 2'b10;
    else if (s >= 0)  return 2'b11;
    else if (s >= -t) return 2'b01;
    else              return 2'b00;
  endfunction

  task automatic check_cycle();
    exp_t e;
    if (sched.size() > 0 && sched[0].at == cyc) begin
      e = sched.pop_front();
      chk("strobe", 64'(sym_valid), 64'(1'b1));
      chk("sym_i", 64'(sym_i), 64'(e.li));
      chk("sym_q", 64'(sym_q), 64'(e.lq));
      last_i  = e.li;
      last_q  = e.lq;
      last_si = e.si;
      last_sq = e.sq;
    end else begin
      chk("no_strobe", 64'(sym_valid), 64'(1'b0));
      chk("hold_i", 64'(sym_i), 64'(last_i));
      chk("hold_q", 64'(sym_q), 64'(last_q));
    end
`ifdef QAM_IQ_DEMOD_SOFT_OUT_EN
    chk("soft_i", 64'($signed(soft_i)), 64'(last_si));
    chk("soft_q", 64'($signed(soft_q)), 64'(last_sq));
`endif
  endtask

  // Apply one cycle of input, update the model, then check the next cycle's outputs
  task automatic drive(input bit v, input int r, input int c, input int s, input bit st);
    exp_t   e;
    longint si;
    longint sq;
    in_valid  = v;
    rx_sample = DW'(r);
    lo_cos    = DW'(c);
    lo_sin    = DW'(s);
    sym_start = st;
    if (v) begin
      if (st) begin
        qi.delete();
        qq.delete();
      end
      qi.push_back(longint'(r) * c);
      qq.push_back(-(longint'(r) * s));
      if (qi.size() == SL) begin
        si = 0;
        sq = 0;
        foreach (qi[k]) begin
          si += qi[k];
          sq += qq[k];
        end
        e.at = cyc + 2;
        e.li = slice(si, longint'(thresh));
        e.lq = slice(sq, longint'(thresh));
        e.si = si;
        e.sq = sq;
        sched.push_back(e);
        qi.delete();
        qq.delete();
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    in_valid  = 1'b0;
    sym_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b0;
    qi.delete();
    qq.delete();
    sched.delete();
    last_i  = 2'b00;
    last_q  = 2'b00;
    last_si = 0;
    last_sq = 0;
    chk("rst_valid", 64'(sym_valid), 64'(1'b0));
    chk("rst_i", 64'(sym_i), 64'(2'b00));
    chk("rst_q", 64'(sym_q), 64'(2'b00));
`ifdef QAM_IQ_DEMOD_SOFT_OUT_EN
    chk("rst_soft_i", 64'(soft_i), 64'(0));
    chk("rst_soft_q", 64'(soft_q), 64'(0));
`endif
  endtask

  initial begin
    int     r[SL];
    int     c[SL];
    int     s[SL];
    longint si;
    rst       = 1'b1;
    in_valid  = 1'b0;
    sym_start = 1'b0;
    rx_sample = '0;
    lo_cos    = '0;
    lo_sin    = '0;
    thresh    = AW'(2000000);
    do_reset(2);

    // Strong positive I, zero Q; strobe lands two cycles after the 4th sample
    drive(1'b1, 1000, 1000, 0, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b1, 1000, 1000, 0, 1'b0);
    chk("s1_early", 64'(sym_valid), 64'(1'b0));
    idle(1);
    chk("s1_valid", 64'(sym_valid), 64'(1'b1));
    chk("s1_i", 64'(sym_i), 64'(2'b10));
    chk("s1_q", 64'(sym_q), 64'(2'b11));
`ifdef QAM_IQ_DEMOD_SOFT_OUT_EN
    chk("s1_soft_i", 64'(soft_i), 64'(4000000));
`endif
    idle(1);

    // Back-to-back symbols: strong negative Q, then small negative I
    for (int k = 0; k < 4; k++) drive(1'b1, 1000, 0, 1000, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b1, -1, 1, 0, 1'b0);
    idle(2);
    chk("s3_i", 64'(sym_i), 64'(2'b01));
    chk("s3_q", 64'(sym_q), 64'(2'b11));

    // Sums sitting exactly on +T and -T
    for (int k = 0; k < 4; k++) drive(1'b1, 1000, 500, 0, 1'b0);
    idle(2);
    chk("bnd_pos_i", 64'(sym_i), 64'(2'b10));
    for (int k = 0; k < 4; k++) drive(1'b1, -1000, 500, 0, 1'b0);
    idle(2);
    chk("bnd_neg_i", 64'(sym_i), 64'(2'b01));

    // Gapped input
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, -1000, 1000, 700, k == 0);
      drive(1'b0, 0, 0, 0, 1'b0);
    end
    idle(2);
    chk("gap_i", 64'(sym_i), 64'(2'b00));
    chk("gap_q", 64'(sym_q), 64'(2'b10));

    // Restart on the 3rd sample discards the partial symbol
    drive(1'b1, 1000, 1000, 0, 1'b1);
    drive(1'b1, 1000, 1000, 0, 1'b0);
    drive(1'b1, -1000, 100, 0, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b1, -1000, 100, 0, 1'b0);
    idle(3);
    chk("restart_i", 64'(sym_i), 64'(2'b01));

    // Reset mid-symbol
    drive(1'b1, 1000, 1000, 0, 1'b0);
    drive(1'b1, 1000, 1000, 0, 1'b0);
    do_reset(1);
    idle(2);
    for (int k = 0; k < 4; k++) drive(1'b1, 1000, 1000, 0, 1'b0);
    idle(3);
    chk("post_rst_i", 64'(sym_i), 64'(2'b10));

    // Randomized symbols with random gaps, restarts and thresholds (incl. 0 and |S_i|)
    for (int n = 0; n < 40; n++) begin
      si = 0;
      for (int k = 0; k < SL; k++) begin
        r[k] = int'($urandom_range(0, 4000)) - 2000;
        c[k] = int'($urandom_range(0, 4000)) - 2000;
        s[k] = int'($urandom_range(0, 4000)) - 2000;
        si += longint'(r[k]) * c[k];
      end
      case ($urandom_range(0, 3))
        0:       thresh = '0;
        1:       thresh = AW'((si < 0) ? -si : si);
        default: thresh = AW'($urandom_range(0, 9000000));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b1, 1234, -777, 555, 1'b0);
        drive(1'b1, -999, 321, -42, 1'b0);
      end
      for (int k = 0; k < SL; k++) begin
        drive(1'b1, r[k], c[k], s[k], k == 0);
        if ($urandom_range(0, 2) == 0) idle(1);
      end
      idle(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qam_iq_demod.md
# qam_iq_demod

Coherent I/Q correlator and 16-QAM slicer for the receive path. It multiplies each received passband sample by locally generated cosine and sine LO samples, which come from the same lookup-table NCO the transmitter uses. It integrates the products over one symbol period (integrate-and-dump) and slices each axis into a 2-bit Gray-coded level. It sits after the ADC and sample-rate front end and feeds decided symbols to the bit de-mapper.

## Interface
Parameters:
- DATA_WIDTH, 16, width of rx sample and of each LO sample, two's complement
- SYM_LEN, 64, valid samples per symbol; must be ≥2
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(SYM_LEN), accumulator width; guarantees no overflow

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  rx_sample/lo_cos/lo_sin/sym_start valid this cycle
- rx_sample  in  DATA_WIDTH  received sample, signed
- lo_cos  in  DATA_WIDTH  LO cosine, signed
- lo_sin  in  DATA_WIDTH  LO sine, signed
- sym_start  in  1  qualified by in_valid; this sample is the first of a new symbol
- thresh  in  ACC_WIDTH-1  unsigned inner/outer decision threshold, sampled at dump
- sym_valid  out  1  one-cycle strobe, sym_i/sym_q valid
- sym_i  out  2  I-axis level
- sym_q  out  2  Q-axis level

## Operation
- Transmit convention is s = I·cos − Q·sin. Per-sample products: p_i = rx·lo_cos and p_q = −(rx·lo_sin), both 2·DATA_WIDTH signed and sign-extended to ACC_WIDTH. The negation cannot overflow.
- Stage 1 (multiply): registers p_i, p_q, the valid flag and the start flag from each valid input. Idle cycles (in_valid=0) leave the accumulators and counter untouched. Gaps are allowed anywhere.
- Stage 2 (accumulate): a sample counter cnt runs 0..SYM_LEN-1 and advances only on valid products.
  - Valid product with start flag set: acc_i/acc_q are loaded with p_i/p_q and cnt becomes 1. The partial symbol is discarded and no sym_valid is issued for it.
  - Valid product with cnt = SYM_LEN-1 (dump): final sums are acc+p. These sums go to the slicer, acc is cleared to 0 and cnt returns to 0.
  - Any other valid product: acc += p and cnt += 1.
  - Start together with cnt = SYM_LEN-1: start wins, with no dump.
- Slicer, per axis, where S is the final sum and T = thresh zero-extended:
  - S ≥ T → 2'b10 (+3)
  - 0 ≤ S < T → 2'b11 (+1)
  - −T ≤ S < 0 → 2'b01 (−1)
  - S < −T → 2'b00 (−3)
- With T = 0, every non-negative sum maps to 10 and every negative sum maps to 00, since S < −0 is the same as S < 0.

## Timing
- Reset clears sym_valid, sym_i, sym_q, acc_i, acc_q, cnt and the stage-1 valid/start flags to 0.
- Latency: if the SYM_LEN-th valid sample is accepted in cycle t, sym_valid is high in cycle t+2 for exactly one cycle. sym_i and sym_q update in that same cycle and hold until the next strobe.
- Back-to-back symbols with in_valid always high produce one strobe every SYM_LEN cycles. No bubble is inserted.
- Reset asserted mid-symbol discards all in-flight data, including stage-1 contents, and no strobe follows. Accumulation restarts from the first valid sample after reset deasserts.
- thresh is sampled in the dump cycle, t+1.

## Configuration
- QAM_IQ_DEMOD_SOFT_OUT_EN defined: adds output ports soft_i and soft_q (ACC_WIDTH, signed). They carry the registered final sums, update with sym_valid and reset to 0. This supports EVM measurement and a downstream soft decoder.
- Undefined: the ports are absent and no sum registers are kept beyond the accumulators.

## Structure
- Shared package qam_pkg holds:
  - the level constants QAM_LVL_M3 = 2'b00, QAM_LVL_M1 = 2'b01, QAM_LVL_P1 = 2'b11, QAM_LVL_P3 = 2'b10, shared with the transmitter mapper
  - the ACC_WIDTH helper function
- One sub-module, qam_slicer: a combinational one-axis decision taking S and T and producing the 2-bit level. It is instantiated twice.

## Test plan
Bench parameters: DATA_WIDTH=16, SYM_LEN=4, thresh=2000000, in_valid continuous unless stated.
- rx=1000, cos=1000, sin=0 for 4 samples, first with sym_start → S_i=4000000, S_q=0 → sym_i=10, sym_q=11, with sym_valid exactly 2 cycles after the 4th sample.
- rx=1000, cos=0, sin=1000 ×4 → S_q=−4000000 → sym_q=00, sym_i=11. Then rx=−1, cos=1, sin=0 ×4 → sym_i=01, sym_q=11.
- Boundary case: rx=1000, cos=500 ×4 → S_i=2000000=T → sym_i=10. Repeat with rx=−1000 → S_i=−T → sym_i=01.
- in_valid toggling 1-0-1-0 over 4 valid samples → identical result, with the strobe 2 cycles after the last valid sample.
- sym_start asserted on the 3rd sample of a symbol → no strobe for the partial symbol; the next strobe arrives after 4 valid samples counted from the restart.
- rst pulsed after 2 samples → no strobe; all outputs read 0. The next 4 samples yield a correct symbol. With QAM_IQ_DEMOD_SOFT_OUT_EN defined, soft_i=4000000 in the first scenario.
